// File: rtl/counter_2d_core.sv
// counter_2d_core: prescaled two-digit BCD up/down counter with registered
// common-anode 7-segment encodings and a free-running display refresh enable.
module counter_2d_core #(
    parameter int unsigned COUNT_DIV   = 50_000_000,
    parameter int unsigned REFRESH_DIV = 50_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       up_dn,
    input  logic       clr,
    output logic [3:0] tens_bcd,
    output logic [3:0] units_bcd,
    output logic [6:0] tens_seg,
    output logic [6:0] units_seg,
    output logic       refresh_en,
    output logic       wrap
);

    localparam int unsigned CW = $clog2(COUNT_DIV);
    localparam int unsigned RW = $clog2(REFRESH_DIV);

    localparam logic [CW-1:0] CNT_LAST    = CW'(COUNT_DIV - 1);
    localparam logic [RW-1:0] REF_LAST    = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] REF_PRE_HIT = RW'(REFRESH_DIV - 2);
    localparam logic [6:0]    SEG_ZERO    = 7'b1000000;

    logic [CW-1:0] r_cnt_pre;
    logic [RW-1:0] r_ref_pre;
    logic [3:0]    r_tens;
    logic [3:0]    r_units;
    logic [6:0]    r_tens_seg;
    logic [6:0]    r_units_seg;
    logic          r_refresh_en;
    logic          r_wrap;

    logic          w_tick;
    logic [3:0]    w_tens_nxt;
    logic [3:0]    w_units_nxt;
    logic          w_wrap_nxt;

    // Common-anode encoding, bit6..bit0 = g f e d c b a, active-low.
    function automatic logic [6:0] seg_enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Count step is due on the last prescaler cycle while running; clr discards it.
    assign w_tick = run && !clr && (r_cnt_pre == CNT_LAST);

    // Count prescaler: holds while paused so the partial period survives.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_pre <= '0;
        end else if (clr) begin
            r_cnt_pre <= '0;
        end else if (run) begin
            if (r_cnt_pre == CNT_LAST) begin
                r_cnt_pre <= '0;
            end else begin
                r_cnt_pre <= r_cnt_pre + CW'(1);
            end
        end
    end

    // Next digit values and wrap flag for the BCD up/down step.
    always_comb begin
        w_tens_nxt  = r_tens;
        w_units_nxt = r_units;
        w_wrap_nxt  = 1'b0;
        if (clr) begin
            w_tens_nxt  = 4'd0;
            w_units_nxt = 4'd0;
        end else if (w_tick) begin
            if (up_dn) begin
                if (r_units >= 4'd9) begin
                    w_units_nxt = 4'd0;
                    if (r_tens >= 4'd9) begin
                        w_tens_nxt = 4'd0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_tens_nxt = r_tens + 4'd1;
                    end
                end else begin
                    w_units_nxt = r_units + 4'd1;
                end
            end else begin
                if (r_units == 4'd0 || r_units > 4'd9) begin
                    w_units_nxt = 4'd9;
                    if (r_tens == 4'd0 || r_tens > 4'd9) begin
                        w_tens_nxt = 4'd9;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_tens_nxt = r_tens - 4'd1;
                    end
                end else begin
                    w_units_nxt = r_units - 4'd1;
                end
            end
        end
    end

    // Digit and wrap registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tens  <= 4'd0;
            r_units <= 4'd0;
            r_wrap  <= 1'b0;
        end else begin
            r_tens  <= w_tens_nxt;
            r_units <= w_units_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // Segment patterns follow the BCD registers by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tens_seg  <= SEG_ZERO;
            r_units_seg <= SEG_ZERO;
        end else begin
            r_tens_seg  <= seg_enc(r_tens);
            r_units_seg <= seg_enc(r_units);
        end
    end

    // Free-running refresh prescaler; the pulse is registered one count early
    // so it lands on the REFRESH_DIV-th cycle of each period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref_pre    <= '0;
            r_refresh_en <= 1'b0;
        end else begin
            r_refresh_en <= (r_ref_pre == REF_PRE_HIT);
            if (r_ref_pre == REF_LAST) begin
                r_ref_pre <= '0;
            end else begin
                r_ref_pre <= r_ref_pre + RW'(1);
            end
        end
    end

    assign tens_bcd   = r_tens;
    assign units_bcd  = r_units;
    assign tens_seg   = r_tens_seg;
    assign units_seg  = r_units_seg;
    assign refresh_en = r_refresh_en;
    assign wrap       = r_wrap;

endmodule

// File: doc/counter_2d_core.md
Name: counter_2d_core

Overview:
- Upstream stage of the two-digit display multiplexer in the contador_2d design.
- Generates a prescaled count tick and runs a two-digit BCD up/down counter (00–99, wrapping).
- Encodes both digits into registered common-anode (active-low) 7-segment patterns for the mux's tens_seg/units_seg inputs.
- Generates the periodic one-cycle refresh enable that drives the mux's digit-toggle enable.

Parameters:
- COUNT_DIV, 50_000_000, clock cycles per count step (1 Hz at 50 MHz); must be >= 2.
- REFRESH_DIV, 50_000, clock cycles per refresh_en pulse (1 kHz at 50 MHz); must be >= 2.
- Counter widths are $clog2 of each divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous assert, active-low (rst=0 resets).
- run  in  1  level; 1 = prescaler advances, 0 = paused.
- up_dn  in  1  1 = count up, 0 = count down; sampled on the tick cycle.
- clr  in  1  synchronous clear of digits and count prescaler.
- tens_bcd  out  4  tens digit, 0–9.
- units_bcd  out  4  units digit, 0–9.
- tens_seg  out  7  tens pattern, CA active-low, bit6..bit0 = g f e d c b a.
- units_seg  out  7  units pattern, same format.
- refresh_en  out  1  one-cycle pulse every REFRESH_DIV cycles; connects to the mux enable.
- wrap  out  1  one-cycle pulse on 99->00 (up) or 00->99 (down).

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - both prescalers = 0;
  - tens_bcd = units_bcd = 0;
  - tens_seg = units_seg = 7'b1000000;
  - refresh_en = 0, wrap = 0.
- Release is synchronous to the next clk edge.
- Count prescaler:
  - Increments each cycle while run=1 and clr=0.
  - Holds its value while run=0, so a pause does not lose the partial period.
  - At COUNT_DIV-1 with run=1 it returns to 0 and asserts internal tick for that cycle.
- Digit update happens on the edge ending a tick cycle.
  - Up: units+1; units 9 -> 0 with tens+1; 99 -> 00 with wrap=1 for one cycle.
  - Down: units-1; units 0 -> 9 with tens-1; 00 -> 99 with wrap=1 for one cycle.
  - The BCD registers never hold values above 9.
- clr=1:
  - Next edge sets digits to 00 and the count prescaler to 0, and forces wrap=0.
  - clr has priority over a simultaneous tick; that tick is discarded.
- Segment outputs are registered from the BCD registers, giving a 1-cycle latency after a digit change.
- Encoding (g..a):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any other value (unreachable) = 1111111.
- wrap is registered, is high for exactly the cycle after the wrapping edge, and is coincident with the new BCD values.
- Refresh prescaler:
  - Free-running, independent of run, clr and up_dn.
  - refresh_en is registered and high for one cycle every REFRESH_DIV cycles.
  - First pulse is high during the REFRESH_DIV-th cycle after reset release.
- up_dn changing between ticks has no effect until the next tick.
- Reset mid-count abandons the count immediately; there is no partial state on release.

Test Plan:
- Reset: with COUNT_DIV=4, REFRESH_DIV=3, run=1 at count 37, pulse rst=0 mid-cycle -> outputs go immediately to bcd 0/0, segs 1000000/1000000, refresh_en=0, wrap=0.
- Count up: run=1, up_dn=1 from 00 -> units advances every 4 cycles; at 09->10, tens_seg=1111001 and units_seg=1000000 appear one cycle after the BCD change.
- Wraps:
  - Preload to 99 by counting, up_dn=1 -> 00 with one wrap pulse.
  - Then up_dn=0 -> 99 with one wrap pulse; no wrap on 10->09.
- Pause: run=1 for 2 cycles of a period, run=0 for 10 cycles, run=1 -> next increment occurs 2 cycles after resume; digits constant while paused.
- Clear: assert clr on a tick cycle at 45 -> 00 next edge, no increment, wrap=0; the following increment comes 4 run-cycles later.
- Refresh: REFRESH_DIV=3 -> refresh_en is high 1 cycle in 3, period unchanged while toggling run, clr and up_dn; first pulse is on the 3rd cycle after reset release.
